// File: rtl/video_vram_arbiter_pkg.sv
// Shared video definitions: requester IDs, arbiter FSM states, priority-order
// type and the default line budget / CPU slot period.
package video_vram_arbiter_pkg;

  typedef enum logic [1:0] {
    ID_CPU = 2'd0,
    ID_LYR = 2'd1,
    ID_SPR = 2'd2
  } req_id_t;

  typedef enum logic {
    ST_IDLE,
    ST_FETCH
  } arb_state_t;

  // Priority order, p0 is the highest.
  typedef struct packed {
    req_id_t p0;
    req_id_t p1;
    req_id_t p2;
  } prio_order_t;

  localparam int unsigned LINE_BUDGET_DEF     = 760;
  localparam int unsigned CPU_SLOT_PERIOD_DEF = 4;

  localparam prio_order_t ORDER_IDLE     = '{p0: ID_CPU, p1: ID_SPR, p2: ID_LYR};
  localparam prio_order_t ORDER_CPU_SLOT = '{p0: ID_CPU, p1: ID_LYR, p2: ID_SPR};
  localparam prio_order_t ORDER_FETCH    = '{p0: ID_LYR, p1: ID_SPR, p2: ID_CPU};

endpackage

// File: rtl/video_arb_prio_sel.sv
// Combinational 3-way fixed-priority selector.
// Ports:
//   req   [2:0] request vector indexed by requester ID
//   order       priority order (p0 highest)
//   grant [2:0] one-hot grant indexed by requester ID
//   valid       some request was granted
//   id          ID of the granted requester
module video_arb_prio_sel
  import video_vram_arbiter_pkg::*;
(
  input  logic [2:0]  req,
  input  prio_order_t order,
  output logic [2:0]  grant,
  output logic        valid,
  output req_id_t     id
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    id    = ID_CPU;
    if (req[order.p0]) begin
      valid = 1'b1;
      id    = order.p0;
    end else if (req[order.p1]) begin
      valid = 1'b1;
      id    = order.p1;
    end else if (req[order.p2]) begin
      valid = 1'b1;
      id    = order.p2;
    end
    if (valid) grant[id] = 1'b1;
  end

endmodule

// File: rtl/video_vram_arbiter.sv
// VRAM arbiter between CPU, layer fetcher and sprite fetcher.
// Acks are combinational grants; the RAM port is registered on the edge that
// closes the ack cycle, so read data returns (rd_valid) two cycles after ack.
// Ports:
//   clk, rst                 clock, async active-high reset
//   next_line, vblank_pulse  timing strobes
//   cpu_/lyr_/spr_req,_addr  requests (held until ack) and addresses
//   cpu_we, cpu_wrdata       CPU write controls
//   lyr_done                 layer fetch finished for this line
//   cpu_/lyr_/spr_ack        grant pulses
//   ram_addr/_we/_wrdata     registered RAM port; ram_rddata read data
//   rd_valid, rd_id, rd_data read return path
//   overrun                  sticky line-budget overrun flag
module video_vram_arbiter
  import video_vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = 17,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned LINE_BUDGET     = LINE_BUDGET_DEF,
  parameter int unsigned CPU_SLOT_PERIOD = CPU_SLOT_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_line,
  input  logic              vblank_pulse,
  input  logic              cpu_req,
  input  logic              lyr_req,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] lyr_addr,
  input  logic [ADDR_W-1:0] spr_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wrdata,
  input  logic              lyr_done,
  output logic              cpu_ack,
  output logic              lyr_ack,
  output logic              spr_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wrdata,
  input  logic [DATA_W-1:0] ram_rddata,
  output logic              rd_valid,
  output logic [1:0]        rd_id,
  output logic [DATA_W-1:0] rd_data,
  output logic              overrun
);

  localparam int unsigned BUD_W  = (LINE_BUDGET > 1) ? $clog2(LINE_BUDGET) : 1;
  localparam int unsigned SLOT_W = (CPU_SLOT_PERIOD > 1) ? $clog2(CPU_SLOT_PERIOD) : 1;
  localparam logic [BUD_W-1:0]  BUD_LAST = BUD_W'(LINE_BUDGET - 1);
  localparam logic [SLOT_W-1:0] SLOT_CPU = SLOT_W'(CPU_SLOT_PERIOD - 1);

  arb_state_t        state, state_nx;
  logic [BUD_W-1:0]  budget, budget_nx;
  logic [SLOT_W-1:0] slot, slot_nx;
  logic              overrun_nx;
  logic              expire;
  prio_order_t       order;

  logic [2:0]        grant;
  logic              gnt_valid;
  req_id_t           gnt_id;
  logic [ADDR_W-1:0] sel_addr;
  logic              gnt_write;

  logic              p1_valid;
  req_id_t           p1_id;

  always_comb begin
    state_nx   = state;
    budget_nx  = budget;
    slot_nx    = slot;
    overrun_nx = overrun;
    expire     = (state == ST_FETCH) && (budget == BUD_LAST);

    // Set is applied after clear so a coincident vblank loses.
    if (vblank_pulse) overrun_nx = 1'b0;
    if ((state == ST_FETCH) && !lyr_done && (expire || next_line)) overrun_nx = 1'b1;

    if (next_line) begin
      state_nx  = ST_FETCH;
      budget_nx = '0;
      slot_nx   = '0;
    end else if (state == ST_FETCH) begin
      if (lyr_done || expire) begin
        state_nx  = ST_IDLE;
        budget_nx = '0;
        slot_nx   = '0;
      end else begin
        budget_nx = budget + 1'b1;
        slot_nx   = (slot == SLOT_CPU) ? '0 : slot + 1'b1;
      end
    end

    if (state == ST_IDLE)      order = ORDER_IDLE;
    else if (slot == SLOT_CPU) order = ORDER_CPU_SLOT;
    else                       order = ORDER_FETCH;
  end

  video_arb_prio_sel u_sel (
    .req   ({spr_req, lyr_req, cpu_req}),
    .order (order),
    .grant (grant),
    .valid (gnt_valid),
    .id    (gnt_id)
  );

  assign cpu_ack = grant[0] & ~rst;
  assign lyr_ack = grant[1] & ~rst;
  assign spr_ack = grant[2] & ~rst;

  always_comb begin
    sel_addr = cpu_addr;
    case (gnt_id)
      ID_LYR:  sel_addr = lyr_addr;
      ID_SPR:  sel_addr = spr_addr;
      default: sel_addr = cpu_addr;
    endcase
    gnt_write = gnt_valid && (gnt_id == ID_CPU) && cpu_we;
    rd_data   = rd_valid ? ram_rddata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      budget     <= '0;
      slot       <= '0;
      overrun    <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wrdata <= '0;
      p1_valid   <= 1'b0;
      p1_id      <= ID_CPU;
      rd_valid   <= 1'b0;
      rd_id      <= '0;
    end else begin
      state    <= state_nx;
      budget   <= budget_nx;
      slot     <= slot_nx;
      overrun  <= overrun_nx;
      ram_we   <= gnt_write;
      if (gnt_valid) ram_addr <= sel_addr;
      if (gnt_write) ram_wrdata <= cpu_wrdata;
      p1_valid <= gnt_valid && !gnt_write;
      p1_id    <= gnt_id;
      rd_valid <= p1_valid;
      rd_id    <= p1_id;
    end
  end

endmodule

// File: tb/tb_video_vram_arbiter.sv
module tb_video_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst, next_line, vblank_pulse;
  logic        cpu_req, lyr_req, spr_req, cpu_we, lyr_done;
  logic [16:0] cpu_addr, lyr_addr, spr_addr;
  logic [31:0] cpu_wrdata, ram_rddata, ram_wrdata, rd_data;
  logic        cpu_ack, lyr_ack, spr_ack, ram_we, rd_valid, overrun;
  logic [16:0] ram_addr;
  logic [1:0]  rd_id;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  video_vram_arbiter #(
    .ADDR_W(17), .DATA_W(32), .LINE_BUDGET(760), .CPU_SLOT_PERIOD(4)
  ) dut (
    .clk(clk), .rst(rst), .next_line(next_line), .vblank_pulse(vblank_pulse),
    .cpu_req(cpu_req), .lyr_req(lyr_req), .spr_req(spr_req),
    .cpu_addr(cpu_addr), .lyr_addr(lyr_addr), .spr_addr(spr_addr),
    .cpu_we(cpu_we), .cpu_wrdata(cpu_wrdata), .lyr_done(lyr_done),
    .cpu_ack(cpu_ack), .lyr_ack(lyr_ack), .spr_ack(spr_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wrdata(ram_wrdata),
    .ram_rddata(ram_rddata), .rd_valid(rd_valid), .rd_id(rd_id),
    .rd_data(rd_data), .overrun(overrun)
  );

  function automatic logic [31:0] rdpat(input logic [16:0] a);
    return 32'hC0DE_0000 ^ {15'd0, a};
  endfunction

  // Synchronous-read RAM: data for the registered address appears next cycle.
  always @(posedge clk) ram_rddata <= rdpat(ram_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; next_line = 0; vblank_pulse = 0; lyr_done = 0;
    cpu_req = 0; lyr_req = 0; spr_req = 0; cpu_we = 0;
    cpu_addr = '0; lyr_addr = '0; spr_addr = '0; cpu_wrdata = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_acks", {cpu_ack, lyr_ack, spr_ack}, 3'b000);
    chk("rst_ram", {ram_we, ram_addr, ram_wrdata}, '0);
    chk("rst_rd", {rd_valid, rd_id, rd_data}, '0);
    chk("rst_overrun", overrun, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // IDLE: all three requesting -> CPU, sprite, layer
    cpu_addr = 17'h100; spr_addr = 17'h200; lyr_addr = 17'h300;
    cpu_req = 1; spr_req = 1; lyr_req = 1;
    #1 chk("idle_ack0", {cpu_ack, lyr_ack, spr_ack}, 3'b100);
    tick();
    chk("idle_addr0", {ram_we, ram_addr}, {1'b0, 17'h100});
    cpu_req = 0;
    #1 chk("idle_ack1", {cpu_ack, lyr_ack, spr_ack}, 3'b001);
    chk("idle_rdv1", rd_valid, 1'b0);
    tick();
    chk("idle_addr1", ram_addr, 17'h200);
    chk("idle_rd_cpu", {rd_valid, rd_id, rd_data}, {1'b1, 2'd0, rdpat(17'h100)});
    spr_req = 0;
    #1 chk("idle_ack2", {cpu_ack, lyr_ack, spr_ack}, 3'b010);
    tick();
    chk("idle_rd_spr", {rd_valid, rd_id, rd_data}, {1'b1, 2'd2, rdpat(17'h200)});
    lyr_req = 0;
    #1 chk("idle_ack3", {cpu_ack, lyr_ack, spr_ack}, 3'b000);
    tick();
    chk("idle_rd_lyr", {rd_valid, rd_id, rd_data}, {1'b1, 2'd1, rdpat(17'h300)});
    tick();
    chk("idle_rd_end", rd_valid, 1'b0);

    // CPU write at top address: registered with the ack, no read return
    cpu_addr = 17'h1FFFF; cpu_wrdata = 32'hDEADBEEF; cpu_we = 1; cpu_req = 1;
    #1 chk("wr_ack", {cpu_ack, lyr_ack, spr_ack}, 3'b100);
    tick();
    chk("wr_port", {ram_we, ram_addr, ram_wrdata}, {1'b1, 17'h1FFFF, 32'hDEADBEEF});
    cpu_req = 0; cpu_we = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_no_rdv", {ram_we, rd_valid}, 2'b00);
    end

    // FETCH slot pattern: layer on slots 0-2, CPU on slot 3
    next_line = 1;
    tick();
    next_line = 0; cpu_req = 1; lyr_req = 1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("fetch_slot", {cpu_ack, lyr_ack, spr_ack},
             (i % 4 == 3) ? 3'b100 : 3'b010);
      tick();
    end
    cpu_req = 0; lyr_req = 0; lyr_done = 1;
    tick();
    lyr_done = 0;
    spr_req = 1; lyr_req = 1;
    #1 chk("done_idle_prio", {cpu_ack, lyr_ack, spr_ack}, 3'b001);
    chk("done_no_overrun", overrun, 1'b0);
    spr_req = 0; lyr_req = 0;
    tick();

    // Budget expiry without lyr_done
    next_line = 1;
    tick();
    next_line = 0;
    repeat (759) tick();
    chk("exp_pre_overrun", overrun, 1'b0);
    spr_req = 1; lyr_req = 1;
    #1 chk("exp_last_fetch", {cpu_ack, lyr_ack, spr_ack}, 3'b010);
    tick();
    chk("exp_overrun", overrun, 1'b1);
    #1 chk("exp_idle_prio", {cpu_ack, lyr_ack, spr_ack}, 3'b001);
    spr_req = 0; lyr_req = 0;
    vblank_pulse = 1;
    tick();
    vblank_pulse = 0;
    chk("vblank_clear", overrun, 1'b0);

    // next_line while fetching without lyr_done
    next_line = 1;
    tick();
    tick();
    next_line = 0;
    chk("restart_overrun", overrun, 1'b1);
    lyr_done = 1; vblank_pulse = 1;
    tick();
    lyr_done = 0; vblank_pulse = 0;
    chk("restart_clear", overrun, 1'b0);

    // lyr_done on the expiry cycle counts as done
    next_line = 1;
    tick();
    next_line = 0;
    repeat (759) tick();
    lyr_done = 1;
    tick();
    lyr_done = 0;
    chk("done_exp_overrun", overrun, 1'b0);
    spr_req = 1; lyr_req = 1;
    #1 chk("done_exp_idle", {cpu_ack, lyr_ack, spr_ack}, 3'b001);
    spr_req = 0; lyr_req = 0;
    tick();

    // Reset with a CPU read in flight
    cpu_addr = 17'h1234; cpu_req = 1;
    #1 chk("rstf_ack", cpu_ack, 1'b1);
    tick();
    chk("rstf_addr", ram_addr, 17'h1234);
    cpu_req = 0;
    #2 rst = 1;
    #1 chk("rstf_ram", {ram_we, ram_addr, ram_wrdata}, '0);
    chk("rstf_rd", {rd_valid, rd_id, rd_data, overrun}, '0);
    cpu_addr = 17'h0ABC; cpu_req = 1;
    #1 chk("rstf_acks", {cpu_ack, lyr_ack, spr_ack}, 3'b000);
    tick();
    chk("rstf_no_rdv", rd_valid, 1'b0);
    rst = 0;
    #1 chk("rel_ack", {cpu_ack, lyr_ack, spr_ack}, 3'b100);
    tick();
    chk("rel_addr", ram_addr, 17'h0ABC);
    chk("rel_rdv0", rd_valid, 1'b0);
    cpu_req = 0;
    tick();
    chk("rel_rd", {rd_valid, rd_id, rd_data}, {1'b1, 2'd0, rdpat(17'h0ABC)});
    tick();
    chk("rel_rd_end", rd_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
